// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: controller states, round-robin
// identifiers, the default block size and a small state-class helper.
package mem_arbiter_pkg;

    // 16-bit words per cache block; a block is 2*WORDS_DEF bytes.
    localparam int WORDS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_WRITE = 2'd3
    } arb_state_e;

    typedef enum logic {
        RR_I = 1'b0,
        RR_D = 1'b1
    } rr_e;

    // Returns are only accepted while a fill is in flight.
    function automatic logic is_fill(input arb_state_e s);
        return (s == ST_ISSUE) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/mem_arbiter_addr_gen.sv
// Fill address generator: block-aligns the miss address and adds the byte
// offset of the word currently being issued (2 bytes per word).
//   addr_i : latched miss address
//   cnt_i  : issue counter (word index)
//   addr_o : memory byte address of that word
module mem_arbiter_addr_gen #(
    parameter int WORDS = 8,
    parameter int CNT_W = 3
) (
    input  logic [15:0]      addr_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic [15:0]      addr_o
);

    localparam logic [15:0] BLK_MASK = 16'(2 * WORDS - 1);

    assign addr_o = (addr_i & ~BLK_MASK) + (16'(cnt_i) << 1);

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter shared by the I-cache fill path, the D-cache fill path and
// the D-cache write-through port. One requester owns the memory at a time;
// a fill issues WORDS pipelined reads and steers each returning word (with
// its index) to the owning cache, a write is a single-cycle issue.
//   clk, rst                : clock, synchronous active-high reset
//   i_req/i_addr            : I-cache miss request
//   d_req/d_addr            : D-cache miss request
//   d_wr_req/_addr/_data    : D-cache write-through request
//   mem_rdata/mem_valid     : in-order read returns from memory
//   mem_enable/wr/addr/wdata: memory command
//   i_grant/d_grant         : current owner (registered)
//   i/d_data_valid          : write fill_data into that cache's data array
//   fill_data/word_num      : returning word and its index within the block
//   i/d_fill_done           : pulse with the last word of a fill
//   d_wr_done               : pulse in the cycle the write is issued
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    localparam int CNT_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [15:0]      i_addr,
    input  logic             d_req,
    input  logic [15:0]      d_addr,
    input  logic             d_wr_req,
    input  logic [15:0]      d_wr_addr,
    input  logic [15:0]      d_wr_data,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_valid,
    output logic             mem_enable,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             i_grant,
    output logic             d_grant,
    output logic             i_data_valid,
    output logic             d_data_valid,
    output logic [15:0]      fill_data,
    output logic [CNT_W-1:0] word_num,
    output logic             i_fill_done,
    output logic             d_fill_done,
    output logic             d_wr_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    arb_state_e       state_q, state_d;
    rr_e              owner_q, owner_d;
    rr_e              last_q, last_d;
    logic [15:0]      addr_q, addr_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
    logic             i_grant_q, i_grant_d;
    logic             d_grant_q, d_grant_d;

    logic             ret_valid;
    logic             last_ret;
    logic             d_pend;
    logic             serve_d;
    logic [15:0]      fill_addr;

    mem_arbiter_addr_gen #(
        .WORDS (WORDS),
        .CNT_W (CNT_W)
    ) u_addr_gen (
        .addr_i (addr_q),
        .cnt_i  (issue_cnt_q),
        .addr_o (fill_addr)
    );

    // Returns outside a fill (IDLE/WRITE) are dropped entirely.
    assign ret_valid = mem_valid & is_fill(state_q);
    assign last_ret  = ret_valid & (ret_cnt_q == LAST_IDX);

    // D is served if I was served last, or if I is not asking at all.
    assign d_pend  = d_wr_req | d_req;
    assign serve_d = d_pend & ((last_q == RR_I) | ~i_req);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 16'h0000;
        d_wr_done   = 1'b0;

        if (ret_valid) begin
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                if (serve_d) begin
                    owner_d = RR_D;
                    last_d  = RR_D;
                    if (d_wr_req) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_ISSUE;
                        addr_d  = d_addr;
                    end
                end else if (i_req) begin
                    owner_d = RR_I;
                    last_d  = RR_I;
                    state_d = ST_ISSUE;
                    addr_d  = i_addr;
                end
            end
            ST_ISSUE: begin
                mem_enable  = 1'b1;
                mem_addr    = fill_addr;
                issue_cnt_d = issue_cnt_q + CNT_W'(1);
                if (last_ret) begin
                    state_d = ST_IDLE;
                end else if (issue_cnt_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_ret) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // Write inputs are held by the D-cache until d_wr_done.
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = d_wr_addr;
                mem_wdata  = d_wr_data;
                d_wr_done  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Grants follow the next state so they rise with the first
        // ISSUE/WRITE cycle and fall when the controller returns to IDLE.
        i_grant_d = (state_d != ST_IDLE) && (owner_d == RR_I);
        d_grant_d = (state_d != ST_IDLE) && (owner_d == RR_D);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= RR_I;
            last_q      <= RR_I;
            addr_q      <= 16'h0000;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            i_grant_q   <= 1'b0;
            d_grant_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            i_grant_q   <= i_grant_d;
            d_grant_q   <= d_grant_d;
        end
    end

    assign i_grant      = i_grant_q;
    assign d_grant      = d_grant_q;
    assign i_data_valid = ret_valid & i_grant_q;
    assign d_data_valid = ret_valid & d_grant_q;
    assign i_fill_done  = last_ret & i_grant_q;
    assign d_fill_done  = last_ret & d_grant_q;
    assign fill_data    = mem_rdata;
    assign word_num     = ret_cnt_q;

endmodule
